// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - shared element geometry for the ReLU forward/backward blocks
package relu_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_NUM_ELEMENTS = 16;
    localparam int DEF_MASK_DEPTH   = 4;
    localparam int MASK_WIDTH       = DEF_NUM_ELEMENTS;

    // Bit index of the sign bit of a lane inside a packed tensor
    function automatic int sign_bit_idx(input int lane, input int data_width);
        return lane * data_width + data_width - 1;
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// rtl/relu_mask_fifo.sv - small FIFO of per-tensor ReLU sign masks
module relu_mask_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/relu_grad_unit.sv
// rtl/relu_grad_unit.sv - ReLU backward pass: masks upstream gradients with stored forward signs
module relu_grad_unit
    import relu_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_ELEMENTS = DEF_NUM_ELEMENTS,
    parameter int MASK_DEPTH   = DEF_MASK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               fwd_valid,
    output logic                               fwd_ready,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] fwd_tensor,
    input  logic                               grad_valid,
    output logic                               grad_ready,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0] grad_tensor,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0] out_tensor,
    output logic [$clog2(MASK_DEPTH+1)-1:0]    mask_count
);

    localparam int TW = NUM_ELEMENTS * DATA_WIDTH;
    localparam int CW = $clog2(MASK_DEPTH + 1);

    logic [NUM_ELEMENTS-1:0] fwd_mask;
    logic [NUM_ELEMENTS-1:0] pop_mask;
    logic [TW-1:0]           masked_grad;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    // Zero is treated as positive so the gradient passes, matching the forward select
    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_lane
        assign fwd_mask[i] = ~fwd_tensor[sign_bit_idx(i, DATA_WIDTH)];
        assign masked_grad[i*DATA_WIDTH +: DATA_WIDTH] =
            pop_mask[i] ? grad_tensor[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign fwd_ready  = !fifo_full && !flush;
    assign grad_ready = !fifo_empty && (!out_valid || out_ready) && !flush;
    assign push       = fwd_valid && fwd_ready;
    assign pop        = grad_valid && grad_ready;

    relu_mask_fifo #(
        .WIDTH (NUM_ELEMENTS),
        .DEPTH (MASK_DEPTH),
        .CW    (CW)
    ) u_mask_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (fwd_mask),
        .pop       (pop),
        .pop_data  (pop_mask),
        .count     (mask_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Flush drops the pending beat but keeps out_tensor for debug visibility
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_tensor <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_tensor <= masked_grad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_grad_unit.sv
// tb/tb_relu_grad_unit.sv - directed self-checking bench for relu_grad_unit
module tb_relu_grad_unit;

    localparam int DW = 8;
    localparam int NE = 16;
    localparam int MD = 4;
    localparam int TW = DW * NE;
    localparam int CW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          fwd_valid = 1'b0;
    logic          fwd_ready;
    logic [TW-1:0] fwd_tensor = '0;
    logic          grad_valid = 1'b0;
    logic          grad_ready;
    logic [TW-1:0] grad_tensor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TW-1:0] out_tensor;
    logic [CW-1:0] mask_count;

    int errors = 0;
    int checks = 0;

    relu_grad_unit #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE), .MASK_DEPTH(MD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fwd_valid   (fwd_valid),
        .fwd_ready   (fwd_ready),
        .fwd_tensor  (fwd_tensor),
        .grad_valid  (grad_valid),
        .grad_ready  (grad_ready),
        .grad_tensor (grad_tensor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_tensor  (out_tensor),
        .mask_count  (mask_count)
    );

    always #5 clk = ~clk;

    // Forward tensor whose lane signs encode m (1 = non-negative), mixing boundary values
    function automatic logic [TW-1:0] fwd_of(input logic [NE-1:0] m);
        logic [TW-1:0] t;
        for (int i = 0; i < NE; i++)
            t[i*DW +: DW] = m[i] ? ((i % 2) ? 8'h00 : 8'h37) : ((i % 2) ? 8'hFF : 8'h80);
        return t;
    endfunction

    function automatic logic [TW-1:0] exp_out(input logic [NE-1:0] m, input logic [DW-1:0] g);
        logic [TW-1:0] t;
        for (int i = 0; i < NE; i++)
            t[i*DW +: DW] = m[i] ? g : 8'h00;
        return t;
    endfunction

    function automatic logic [TW-1:0] splat(input logic [DW-1:0] g);
        return {NE{g}};
    endfunction

    task automatic test_reset();
        logic [TW-1:0] zero_t;
        zero_t = '0;
        grad_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_tensor !== zero_t) begin errors++; $display("FAIL reset_out_tensor got=%h exp=%h", out_tensor, zero_t); end
        rst_n = 1'b1;
        #1;
        checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", mask_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL reset_fwd_ready got=%b exp=1", fwd_ready); end
        checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL reset_grad_ready got=%b exp=0", grad_ready); end
        grad_valid = 1'b0;
    endtask

    task automatic test_mask_extract();
        logic [TW-1:0] exp_t;
        exp_t = {{12{8'h05}}, 8'h00, 8'h05, 8'h05, 8'h00};
        @(negedge clk);
        fwd_tensor = {{12{8'h01}}, 8'hFF, 8'h7F, 8'h00, 8'h80};
        fwd_valid = 1'b1;
        #1;
        checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL mx_fwd_ready got=%b exp=1", fwd_ready); end
        @(negedge clk);
        fwd_valid = 1'b0;
        checks++; if (mask_count !== 3'd1) begin errors++; $display("FAIL mx_count got=%0d exp=1", mask_count); end
        grad_tensor = splat(8'h05);
        grad_valid = 1'b1;
        #1;
        checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL mx_grad_ready got=%b exp=1", grad_ready); end
        @(negedge clk);
        grad_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mx_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_tensor !== exp_t) begin errors++; $display("FAIL mx_out_tensor got=%h exp=%h", out_tensor, exp_t); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mx_out_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_full_order();
        logic [NE-1:0] lm [4];
        lm = '{16'hFFFF, 16'h00FF, 16'hA5A5, 16'h0000};
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            fwd_tensor = fwd_of(lm[k]);
            fwd_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (mask_count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", mask_count); end
        fwd_tensor = fwd_of(16'h1234);
        #1;
        checks++; if (fwd_ready !== 1'b0) begin errors++; $display("FAIL full_fwd_ready got=%b exp=0", fwd_ready); end
        repeat (2) @(negedge clk);
        checks++; if (mask_count !== 3'd4) begin errors++; $display("FAIL full_stall_count got=%0d exp=4", mask_count); end
        fwd_valid = 1'b0;
        grad_tensor = splat(8'h7E);
        for (int k = 0; k < 4; k++) begin
            grad_valid = 1'b1;
            #1;
            checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL order_grad_ready[%0d] got=%b exp=1", k, grad_ready); end
            if (k == 0) begin
                checks++; if (fwd_ready !== 1'b0) begin errors++; $display("FAIL order_no_bypass got=%b exp=0", fwd_ready); end
            end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL order_out_valid[%0d] got=%b exp=1", k, out_valid); end
            checks++; if (out_tensor !== exp_out(lm[k], 8'h7E)) begin errors++; $display("FAIL order_out[%0d] got=%h exp=%h", k, out_tensor, exp_out(lm[k], 8'h7E)); end
            if (k == 0) begin
                checks++; if (fwd_ready !== 1'b1) begin errors++; $display("FAIL order_fwd_ready_back got=%b exp=1", fwd_ready); end
            end
        end
        grad_valid = 1'b0;
        checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL order_count_end got=%0d exp=0", mask_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL order_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_empty_stall();
        @(negedge clk);
        grad_tensor = splat(8'hC3);
        grad_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL empty_stall[%0d] got=%b exp=0", k, grad_ready); end
            @(negedge clk);
        end
        fwd_tensor = fwd_of(16'h0F0F);
        fwd_valid = 1'b1;
        #1;
        checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL empty_push_cycle got=%b exp=0", grad_ready); end
        @(negedge clk);
        fwd_valid = 1'b0;
        #1;
        checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL empty_next_cycle got=%b exp=1", grad_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_out_early got=%b exp=0", out_valid); end
        @(negedge clk);
        grad_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_tensor !== exp_out(16'h0F0F, 8'hC3)) begin errors++; $display("FAIL empty_out got=%h exp=%h", out_tensor, exp_out(16'h0F0F, 8'hC3)); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] exp_a;
        logic [TW-1:0] exp_b;
        exp_a = exp_out(16'h3C3C, 8'h5A);
        exp_b = exp_out(16'hF00F, 8'h96);
        @(negedge clk);
        fwd_tensor = fwd_of(16'h3C3C); fwd_valid = 1'b1;
        @(negedge clk);
        fwd_tensor = fwd_of(16'hF00F);
        @(negedge clk);
        fwd_valid = 1'b0;
        out_ready = 1'b0;
        grad_tensor = splat(8'h5A);
        grad_valid = 1'b1;
        #1;
        checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL bp_first_accept got=%b exp=1", grad_ready); end
        @(negedge clk);
        grad_tensor = splat(8'h96);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL bp_grad_ready[%0d] got=%b exp=0", k, grad_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", k, out_valid); end
            checks++; if (out_tensor !== exp_a) begin errors++; $display("FAIL bp_hold[%0d] got=%h exp=%h", k, out_tensor, exp_a); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", grad_ready); end
        @(negedge clk);
        grad_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%b exp=1", out_valid); end
        checks++; if (out_tensor !== exp_b) begin errors++; $display("FAIL bp_second got=%h exp=%h", out_tensor, exp_b); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_simul_push_pop();
        logic [NE-1:0] sm [12];
        sm = '{16'h0001, 16'h8000, 16'hFF00, 16'h0FF0, 16'hAAAA, 16'h5555,
               16'h1248, 16'h8421, 16'hF0F0, 16'h3333, 16'hCCCC, 16'h7FFE};
        @(negedge clk);
        fwd_tensor = fwd_of(sm[0]); fwd_valid = 1'b1;
        @(negedge clk);
        fwd_tensor = fwd_of(sm[1]);
        @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            fwd_tensor = fwd_of(sm[j+2]);
            fwd_valid = 1'b1;
            grad_tensor = splat(8'(8'h30 + j));
            grad_valid = 1'b1;
            #1;
            checks++; if ({fwd_ready, grad_ready} !== 2'b11) begin errors++; $display("FAIL pp_ready[%0d] got=%b exp=11", j, {fwd_ready, grad_ready}); end
            @(negedge clk);
            checks++; if (mask_count !== 3'd2) begin errors++; $display("FAIL pp_count[%0d] got=%0d exp=2", j, mask_count); end
            checks++; if (out_tensor !== exp_out(sm[j], 8'(8'h30 + j))) begin errors++; $display("FAIL pp_out[%0d] got=%h exp=%h", j, out_tensor, exp_out(sm[j], 8'(8'h30 + j))); end
        end
        fwd_valid = 1'b0;
        for (int j = 10; j < 12; j++) begin
            grad_tensor = splat(8'(8'h30 + j));
            @(negedge clk);
            checks++; if (out_tensor !== exp_out(sm[j], 8'(8'h30 + j))) begin errors++; $display("FAIL pp_tail[%0d] got=%h exp=%h", j, out_tensor, exp_out(sm[j], 8'(8'h30 + j))); end
        end
        grad_valid = 1'b0;
        checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL pp_count_end got=%0d exp=0", mask_count); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [NE-1:0] fm [4];
        logic [TW-1:0] held;
        fm = '{16'h8001, 16'h4002, 16'h2004, 16'h1008};
        held = exp_out(16'h8001, 8'h6B);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            fwd_tensor = fwd_of(fm[k]); fwd_valid = 1'b1;
            @(negedge clk);
        end
        fwd_valid = 1'b0;
        out_ready = 1'b0;
        grad_tensor = splat(8'h6B);
        grad_valid = 1'b1;
        @(negedge clk);
        checks++; if (mask_count !== 3'd3) begin errors++; $display("FAIL fl_pre_count got=%0d exp=3", mask_count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_pre_valid got=%b exp=1", out_valid); end
        flush = 1'b1;
        fwd_tensor = fwd_of(16'hFFFF); fwd_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if ({fwd_ready, grad_ready} !== 2'b00) begin errors++; $display("FAIL fl_readies got=%b exp=00", {fwd_ready, grad_ready}); end
        @(negedge clk);
        flush = 1'b0;
        fwd_valid = 1'b0;
        checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL fl_count got=%0d exp=0", mask_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_tensor !== held) begin errors++; $display("FAIL fl_out_tensor got=%h exp=%h", out_tensor, held); end
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (grad_ready !== 1'b0) begin errors++; $display("FAIL fl_stall[%0d] got=%b exp=0", k, grad_ready); end
            @(negedge clk);
        end
        grad_tensor = splat(8'h21);
        fwd_tensor = fwd_of(16'h00FF); fwd_valid = 1'b1;
        @(negedge clk);
        fwd_valid = 1'b0;
        #1;
        checks++; if (grad_ready !== 1'b1) begin errors++; $display("FAIL fl_resume got=%b exp=1", grad_ready); end
        @(negedge clk);
        grad_valid = 1'b0;
        checks++; if (out_tensor !== exp_out(16'h00FF, 8'h21)) begin errors++; $display("FAIL fl_resume_out got=%h exp=%h", out_tensor, exp_out(16'h00FF, 8'h21)); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [TW-1:0] zero_t;
        zero_t = '0;
        @(negedge clk);
        fwd_tensor = fwd_of(16'hFFFF); fwd_valid = 1'b1;
        @(negedge clk);
        fwd_tensor = fwd_of(16'h7777);
        @(negedge clk);
        fwd_valid = 1'b0;
        out_ready = 1'b0;
        grad_tensor = splat(8'h44);
        grad_valid = 1'b1;
        @(negedge clk);
        grad_valid = 1'b0;
        checks++; if ({out_valid, mask_count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL ar_pre got=%b exp=1001", {out_valid, mask_count}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mask_count !== 3'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", mask_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_tensor !== zero_t) begin errors++; $display("FAIL ar_out_tensor got=%h exp=%h", out_tensor, zero_t); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        grad_valid = 1'b1;
        #1;
        checks++; if ({fwd_ready, grad_ready} !== 2'b10) begin errors++; $display("FAIL ar_readies got=%b exp=10", {fwd_ready, grad_ready}); end
        @(negedge clk);
        grad_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mask_extract();
        test_full_order();
        test_empty_stall();
        test_backpressure();
        test_simul_push_pop();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/relu_grad_unit.md
Name: relu_grad_unit

Overview:
Backward-pass counterpart of the forward ReLU array in the residual block.
- Forward side: captures one sign mask per forward tensor and queues it in a small mask FIFO.
- Backward side: accepts upstream gradient tensors in the same order, pops the matching mask and zeroes gradient elements whose forward input was negative.
- Sits between the residual-add backward path and the conv backward path; all three streams use valid/ready.

Parameters:
DATA_WIDTH, 8, bits per signed element (forward activation and gradient).
NUM_ELEMENTS, 16, elements per tensor beat.
MASK_DEPTH, 4, number of forward masks that can be outstanding (power of 2, >=2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all stored masks and the output stage
fwd_valid  input  1  forward tensor present
fwd_ready  output  1  mask FIFO can accept
fwd_tensor  input  NUM_ELEMENTS*DATA_WIDTH  forward ReLU input tensor, element i at [i*DATA_WIDTH +: DATA_WIDTH]
grad_valid  input  1  upstream gradient present
grad_ready  output  1  gradient accepted this cycle
grad_tensor  input  NUM_ELEMENTS*DATA_WIDTH  upstream gradient, same packing
out_valid  output  1  masked gradient present
out_ready  input  1  downstream accepts
out_tensor  output  NUM_ELEMENTS*DATA_WIDTH  masked gradient
mask_count  output  $clog2(MASK_DEPTH+1)  masks currently stored

Behaviour:
- Reset (rst_n low, async): FIFO empty, mask_count=0, out_valid=0, out_tensor=0. fwd_ready=1 and grad_ready=0 once reset is released.
- Mask rule: mask[i] = ~fwd_tensor[i*DATA_WIDTH+DATA_WIDTH-1]. Zero counts as positive (mask=1), matching the forward select.
- Forward push: when fwd_valid && fwd_ready, write the NUM_ELEMENTS-bit mask at the write pointer.
  - fwd_ready = (mask_count < MASK_DEPTH) && !flush.
  - No same-cycle bypass when full: a pop in the same cycle does not raise fwd_ready.
- Gradient accept: grad_ready = (mask_count != 0) && (!out_valid || out_ready) && !flush.
  - On accept, pop the mask and register out_tensor[i] = mask[i] ? grad[i] : 0. Latency is exactly 1 cycle.
  - out_valid rises the next cycle.
- Output: out_valid/out_tensor hold stable until out_ready. Back-to-back throughput is one tensor per cycle while out_ready stays high.
- Pointers: write and read pointers are $clog2(MASK_DEPTH) bits and wrap modulo MASK_DEPTH. mask_count increments on push only, decrements on pop only, and is unchanged on a simultaneous push and pop.
- Empty FIFO with a push in cycle N: the mask becomes poppable in cycle N+1 (grad_ready is low in cycle N).
- Gradient beat with no stored mask: stalls (grad_ready=0); never popped against a stale mask.
- Flush (sync, high for one or more cycles):
  - pointers and mask_count go to 0;
  - out_valid goes to 0 the next cycle; out_tensor is left unchanged;
  - fwd_ready and grad_ready are 0 while flush is high.
  - Flush dominates any simultaneous push, pop or output handshake.
- Reset mid-operation: immediate clear as above, regardless of in-flight handshakes.
- Width rule: gradient elements pass through bit-exact. No arithmetic, no saturation.

Decomposition:
- Shared package relu_pkg:
  - DATA_WIDTH and NUM_ELEMENTS defaults (shared with relu_array);
  - element slice helper constants;
  - mask width localparam NUM_ELEMENTS.
- One sub-module, relu_mask_fifo:
  - parameterised width NUM_ELEMENTS, depth MASK_DEPTH;
  - push/pop/flush, count, full/empty;
  - asynchronous active-low reset.
- Top level holds the mask extraction, gradient masking and output register.

Test Plan:
- Mask extraction (DATA_WIDTH=8): push fwd elements {0x80,0x00,0x7F,0xFF} in lanes 0-3, rest 0x01; then grad all 0x05 -> out lanes 0-3 = {0x00,0x05,0x05,0x00}, others 0x05, one cycle after grad accept.
- Ordering and full: push 4 distinct masks -> mask_count=4, fwd_ready=0.
  - A 5th push stalls.
  - 4 gradients pop the masks in push order.
  - fwd_ready returns the cycle after the first pop.
- Empty stall: grad_valid=1 with no masks -> grad_ready=0 indefinitely. A push in cycle N -> grad accepted in cycle N+1, out_valid in N+2.
- Backpressure: out_ready=0 for 3 cycles with a second gradient waiting -> out_tensor stable, grad_ready=0. out_ready=1 -> both beats drain on consecutive cycles.
- Simultaneous push+pop at mask_count=2 -> count stays 2. Wrap-around verified over 10 push/pop pairs with correct mask pairing.
- Flush with mask_count=3 and out_valid=1 -> next cycle mask_count=0, out_valid=0. A subsequent grad stalls until a new push. Async rst_n pulse mid-stream gives the same result.
